// File: rtl/rxfifo_if.sv
// Receiver-side and CPU-side signals of the receive buffer, bundled for the rxfifo port list.
interface rxfifo_if #(
  parameter int LOG2DEPTH = 4
);
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_rd;
  logic                 rd;
  logic                 valid;
  logic [7:0]           data;
  logic [LOG2DEPTH:0]   level;
  logic                 overrun;
  logic                 clr_overrun;

  // Handshake: the receiver holds rx_valid/rx_data until it sees rx_rd; rx_rd is
  // asserted in the same cycle as rx_valid, so every byte is taken (stored or dropped)
  // on that edge. On the CPU side, rd pops the head only while valid=1; rd while
  // valid=0 is ignored.
  modport slave (
    input  rx_valid, rx_data, rd, clr_overrun,
    output rx_rd, valid, data, level, overrun
  );

  modport master (
    output rx_valid, rx_data, rd, clr_overrun,
    input  rx_rd, valid, data, level, overrun
  );
endinterface

// File: rtl/rxfifo.sv
// Receive buffer behind the serial receiver: first-word-fall-through FIFO with
// fill level and sticky overrun flag. The receiver is never stalled.
module rxfifo #(
  parameter int LOG2DEPTH = 4
) (
  input  logic    clk,
  input  logic    resetq,
  rxfifo_if.slave bus
);
  localparam int DEPTH = 2 ** LOG2DEPTH;
  localparam int CW    = LOG2DEPTH + 1;

  logic [7:0]           mem_q [DEPTH];
  logic [LOG2DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG2DEPTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;

  logic full, empty, pop, push, drop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = bus.rd & ~empty;
  // A pop in the same cycle frees a slot, so a byte arriving while full is still kept.
  assign push  = bus.rx_valid & (~full | pop);
  assign drop  = bus.rx_valid & full & ~pop;

  // Release depends only on rx_valid; held low while in reset.
  assign bus.rx_rd   = bus.rx_valid & resetq;
  assign bus.valid   = ~empty;
  assign bus.data    = mem_q[rptr_q];
  assign bus.level   = count_q;
  assign bus.overrun = overrun_q;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop wins over a simultaneous clear.
    if (drop)                 overrun_d = 1'b1;
    else if (bus.clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.rx_data;
  end
endmodule
